// File: rtl/bmi_bit_gather_ctrl_pkg.sv
// Shared types and sizes for the BMI bit-gather sequencer.
// Used by the control block in both builds (BMI_GATHER_SKIP_ZERO_EN defined or not).
package bmi_pkg;
    localparam int DATA_W = 256;
    localparam int SEL_W  = 8;
    localparam int CNT_W  = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } gather_state_t;

    // Plain vector encodings of the states, used for the state register.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SCAN = SCAN;
    localparam logic [1:0] ST_DONE = DONE;
endpackage

// File: rtl/bmi_bit_gather_ctrl_if.sv
// Request / mux / result bundle between ALU issue logic, the gather sequencer and the 256:1 bit mux.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface bmi_gather_if;
    import bmi_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_src;
    logic [DATA_W-1:0] req_mask;
    logic [DATA_W-1:0] mux_src;
    logic [SEL_W-1:0]  mux_sel;
    logic              mux_bit;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [CNT_W-1:0]  res_count;
    logic              busy;

    modport slave (
        input  req_valid, req_src, req_mask, mux_bit, res_ready,
        output req_ready, mux_src, mux_sel, res_valid, res_data, res_count, busy
    );

    modport master (
        output req_valid, req_src, req_mask, mux_bit, res_ready,
        input  req_ready, mux_src, mux_sel, res_valid, res_data, res_count, busy
    );
endinterface

// File: rtl/bmi_bit_gather_ctrl_next_one.sv
// Priority encoder: lowest set bit of vec at index >= base, with a none-found flag.
// Only instantiated when BMI_GATHER_SKIP_ZERO_EN is defined.
module bmi_next_one
    import bmi_pkg::*;
(
    input  logic [DATA_W-1:0] vec,
    input  logic [SEL_W-1:0]  base,
    output logic [SEL_W-1:0]  idx,
    output logic              none
);

    // Scan from the top down so the lowest qualifying index wins.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            logic hit;
            hit  = vec[i] && (i >= int'(base));
            idx  = hit ? SEL_W'(i) : idx;
            none = none & ~hit;
        end
    end

endmodule

// File: rtl/bmi_bit_gather_ctrl.sv
// PEXT-style bit gather sequencer driving the shared 256:1 bit mux select.
// Define BMI_GATHER_SKIP_ZERO_EN to visit only set mask bits instead of every position.
module bmi_bit_gather_ctrl
    import bmi_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    bmi_gather_if.slave  bus
);

    logic [1:0]        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q,   ptr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] mask_q,  mask_d;
    logic [DATA_W-1:0] src_q,   src_d;
    logic [DATA_W-1:0] res_q,   res_d;

    logic [SEL_W-1:0]  start_ptr_s;
    logic [SEL_W-1:0]  next_ptr_s;
    logic              last_s;

`ifdef BMI_GATHER_SKIP_ZERO_EN
    logic [DATA_W-1:0] enc_vec_s;
    logic [SEL_W-1:0]  enc_base_s;
    logic [SEL_W-1:0]  enc_idx_s;
    logic              enc_none_s;

    // One encoder serves both the first-bit search at accept and the next-bit search in SCAN.
    assign enc_vec_s  = (state_q == ST_IDLE) ? bus.req_mask : mask_q;
    assign enc_base_s = (state_q == ST_IDLE) ? {SEL_W{1'b0}} : (ptr_q + SEL_W'(1));

    bmi_next_one u_next_one (
        .vec  (enc_vec_s),
        .base (enc_base_s),
        .idx  (enc_idx_s),
        .none (enc_none_s)
    );

    // ptr+1 wraps to 0 at the top position, so the top position is always terminal.
    assign start_ptr_s = enc_idx_s;
    assign next_ptr_s  = enc_idx_s;
    assign last_s      = (ptr_q == {SEL_W{1'b1}}) || enc_none_s;
`else
    assign start_ptr_s = {SEL_W{1'b0}};
    assign next_ptr_s  = ptr_q + SEL_W'(1);
    assign last_s      = (ptr_q == {SEL_W{1'b1}});
`endif

    // Next-state and datapath update for the IDLE/SCAN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        src_d   = src_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_SCAN;
                    src_d   = bus.req_src;
                    mask_d  = bus.req_mask;
                    res_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = start_ptr_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (mask_q[ptr_q]) begin
                    res_d[cnt_q[SEL_W-1:0]] = bus.mux_bit;
                    cnt_d                   = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                // ptr is held on the terminal cycle so mux_sel only moves while scanning.
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    ptr_d = next_ptr_s;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            src_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            src_q   <= src_d;
            res_q   <= res_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.res_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.mux_src   = src_q;
    assign bus.mux_sel   = ptr_q;
    assign bus.res_data  = res_q;
    assign bus.res_count = cnt_q;

endmodule

// File: tb/tb_bmi_bit_gather_ctrl.sv
// Directed, table-driven bench for bmi_bit_gather_ctrl with an ideal 256:1 mux model.
// Expected latency follows BMI_GATHER_SKIP_ZERO_EN when it is defined for the build.
module tb_bmi_bit_gather_ctrl;
    import bmi_pkg::*;

    typedef struct {
        logic [DATA_W-1:0] src;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] exp_data;
        int                exp_count;
        int                hold;
    } vec_t;

    localparam int NVEC = 8;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;
    vec_t tbl [NVEC];

    bmi_gather_if bus ();

    bmi_bit_gather_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mux_bit = bus.mux_src[bus.mux_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input int count);
`ifdef BMI_GATHER_SKIP_ZERO_EN
        return ((count == 0) ? 1 : count) + 1;
`else
        return DATA_W + 1;
`endif
    endfunction

    task automatic run_op(input vec_t v, input int idx);
        int lat;
        bit got;
        @(negedge clk);
        bus.req_src   = v.src;
        bus.req_mask  = v.mask;
        bus.req_valid = 1'b1;
        check($sformatf("v%0d req_ready", idx), bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 400) begin
            if (bus.res_valid) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        check($sformatf("v%0d res_valid seen", idx), got, 1);
        check($sformatf("v%0d latency", idx), lat, exp_latency(v.exp_count));
        check($sformatf("v%0d res_data", idx), bus.res_data, v.exp_data);
        check($sformatf("v%0d res_count", idx), bus.res_count, v.exp_count);
        check($sformatf("v%0d mux_src", idx), bus.mux_src, v.src);
        check($sformatf("v%0d busy/ready", idx), {bus.busy, bus.req_ready}, 2'b10);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            bus.req_valid = h[0];
            bus.req_src   = ~v.src;
            bus.req_mask  = '1;
            @(posedge clk);
            #1;
            check($sformatf("v%0d hold%0d valid/ready", idx, h), {bus.res_valid, bus.req_ready}, 2'b10);
            check($sformatf("v%0d hold%0d res_data", idx, h), bus.res_data, v.exp_data);
            check($sformatf("v%0d hold%0d mux_src", idx, h), bus.mux_src, v.src);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("v%0d after ack", idx), {bus.res_valid, bus.req_ready, bus.busy}, 3'b010);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] r;
        bit                seen;
        n_vec  = 0;
        n_fail = 0;
        for (int k = 0; k < DATA_W / 32; k++) r[k*32 +: 32] = $urandom;

        tbl[0] = '{256'hA0, 256'hF0, 256'hA, 4, 0};
        tbl[1] = '{r, {DATA_W{1'b1}}, r, 256, 10};
        tbl[2] = '{{DATA_W{1'b1}}, {DATA_W{1'b0}}, {DATA_W{1'b0}}, 0, 0};
        tbl[3] = '{{1'b1, 255'd0}, {1'b1, 254'd0, 1'b1}, 256'h2, 2, 0};
        tbl[4] = '{256'h3C00, 256'hFF00, 256'h3C, 8, 0};
        tbl[5] = '{{DATA_W{1'b1}}, {128{2'b10}}, {128'd0, {128{1'b1}}}, 128, 0};
        tbl[6] = '{{1'b1, 255'd0}, {1'b1, 255'd0}, 256'h1, 1, 0};
        tbl[7] = '{{128{2'b01}}, 256'hFFFF, 256'h5555, 16, 0};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_src   = '0;
        bus.req_mask  = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready/valid/busy", {bus.req_ready, bus.res_valid, bus.busy}, 3'b100);
        check("reset res_data", bus.res_data, '0);
        check("reset res_count/mux_sel", {bus.res_count, bus.mux_sel}, '0);
        check("reset mux_src", bus.mux_src, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_op(tbl[i], i);

        // Abort mid-scan with ptr at 100.
        @(negedge clk);
        bus.req_src   = r;
        bus.req_mask  = '1;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("abort mux_sel=100", bus.mux_sel, 100);
        check("abort busy before rst", bus.busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort ready/valid/busy", {bus.req_ready, bus.res_valid, bus.busy}, 3'b100);
        check("abort res_data", bus.res_data, '0);
        check("abort res_count/mux_sel", {bus.res_count, bus.mux_sel}, '0);
        check("abort mux_src", bus.mux_src, '0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            seen = seen | bus.res_valid | bus.busy;
        end
        check("abort no res_valid", seen, 0);

        run_op(tbl[0], 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
